binary_to_bcd_seq: RTL and testbench

Parametrised multi-cycle binary-to-BCD converter for the 7-segment display path. It converts one input bit per clock using double-dabble, with all digits adjusted in parallel. It optionally treats the input as two's complement and reports sign, overflow and a leading-zero blank mask for the digit driver. It sits between the value source and the 7-segment multiplexer, and replaces the per-digit state-machine converter where throughput, signed values or blanking are needed.

---
 rtl/binary_to_bcd_seq_if.sv | 46 ++++
 rtl/binary_to_bcd_seq.sv | 166 ++++++++++++++++
 tb/tb_binary_to_bcd_seq.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/binary_to_bcd_seq_if.sv
// ---------------------------------------------------------------------------
// binary_to_bcd_seq_if
//   Request/result bundle between a value source and the sequential
//   binary-to-BCD converter.
//
//   Handshake: the source raises start with binary stable. The converter
//   accepts on the first rising edge where start=1 and busy=0. A start seen
//   while busy=1 is dropped, not queued. binary is only sampled on the
//   accepting edge. dv pulses for exactly one cycle when bcd/sign/blank/
//   overflow have been updated. Those results then hold until the next dv.
//
//   Signals
//     binary    source -> conv  INPUT_WIDTH       value to convert
//     start     source -> conv  1                 conversion request
//     bcd       conv -> source  DECIMAL_DIGITS*4  result digits, digit 0 = LSD
//     sign      conv -> source  1                 result is negative
//     blank     conv -> source  DECIMAL_DIGITS    leading-zero blank mask
//     overflow  conv -> source  1                 magnitude exceeds digit count
//     busy      conv -> source  1                 conversion in progress
//     dv        conv -> source  1                 one-cycle result-valid pulse
// ---------------------------------------------------------------------------
interface binary_to_bcd_seq_if #(
    parameter int INPUT_WIDTH    = 16,
    parameter int DECIMAL_DIGITS = 5
);
    logic [INPUT_WIDTH-1:0]      binary;
    logic                        start;
    logic [DECIMAL_DIGITS*4-1:0] bcd;
    logic                        sign;
    logic [DECIMAL_DIGITS-1:0]   blank;
    logic                        overflow;
    logic                        busy;
    logic                        dv;

    // Value source side
    modport master (
        output binary, start,
        input  bcd, sign, blank, overflow, busy, dv
    );

    // Converter side
    modport slave (
        input  binary, start,
        output bcd, sign, blank, overflow, busy, dv
    );
endinterface

// File: rtl/binary_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// binary_to_bcd_seq
//   Multi-cycle double-dabble binary-to-BCD converter for the 7-segment
//   display path. One input bit is shifted per clock, with every internal
//   digit adjusted in parallel. It can treat the input as two's complement
//   and reports sign, overflow and a leading-zero blank mask.
//
//   Ports
//     i_Clock    in   rising-edge clock
//     i_Reset_n  in   asynchronous active-low reset
//     bus        slave modport of binary_to_bcd_seq_if (request + results)
//     dbg_state  out  current FSM state (0 idle, 1 convert, 2 finish)
//
//   Timing: accept on E0. Shift on E1..E_W. Results and dv appear after
//   E_(W+1). The dv cycle is already idle, so back-to-back starts are
//   accepted there.
// ---------------------------------------------------------------------------
module binary_to_bcd_seq #(
    parameter int INPUT_WIDTH    = 16,
    parameter int DECIMAL_DIGITS = 5,
    parameter int SIGNED         = 0
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
    binary_to_bcd_seq_if.slave   bus,
    output logic [1:0]           dbg_state
);
    // ceil(W/3) digits always hold a W-bit magnitude.
    localparam int NI = (INPUT_WIDTH + 2) / 3;
    localparam int CW = $clog2(INPUT_WIDTH + 1);
    // Working width wide enough for both the internal and displayed digits.
    localparam int XD = (NI > DECIMAL_DIGITS) ? NI : DECIMAL_DIGITS;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_FINISH  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [INPUT_WIDTH-1:0]      shreg;
    logic [NI*4-1:0]             bcd_reg;
    logic [CW-1:0]               cnt;
    logic                        sign_lat;

    logic [DECIMAL_DIGITS*4-1:0] bcd_q;
    logic                        sign_q;
    logic [DECIMAL_DIGITS-1:0]   blank_q;
    logic                        ovf_q;
    logic                        dv_q;
    logic                        busy_c;

    logic                        accept;
    logic                        neg;
    logic [INPUT_WIDTH-1:0]      mag;
    logic [NI*4-1:0]             adj;
    logic [XD*4-1:0]             ext;
    logic [DECIMAL_DIGITS*4-1:0] disp;
    logic                        ovf_c;
    logic [DECIMAL_DIGITS-1:0]   blank_c;
    logic                        zero_above;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) state <= S_IDLE;
        else            state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (bus.start) state_next = S_CONVERT;
            S_CONVERT: if (cnt == CW'(INPUT_WIDTH - 1)) state_next = S_FINISH;
            S_FINISH:  state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy_c    = (state != S_IDLE);
        dbg_state = state;
    end

    assign accept = (state == S_IDLE) && bus.start;

    // Two's complement magnitude. Negating the most negative value wraps to
    // 2^(W-1), which is exactly the correct unsigned magnitude.
    always_comb begin
        neg = (SIGNED != 0) && bus.binary[INPUT_WIDTH-1];
        mag = bus.binary;
        if (neg) mag = ~bus.binary + INPUT_WIDTH'(1);
    end

    // Add-3 adjust on every digit before the shift.
    always_comb begin
        adj = bcd_reg;
        for (int i = 0; i < NI; i++) begin
            if (bcd_reg[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
        end
    end

    // Map internal digits onto the displayed digits. Digits above NI are
    // zero, and digits at or above DECIMAL_DIGITS are only overflow.
    always_comb begin
        ext = '0;
        ext[NI*4-1:0] = bcd_reg;
        disp  = ext[DECIMAL_DIGITS*4-1:0];
        ovf_c = (ext >> (DECIMAL_DIGITS * 4)) != '0;
    end

    // Scan from the top digit down. A digit is blanked while it and
    // everything above it are zero. Digit 0 is never blanked, and nothing is
    // blanked on overflow because the shown digits are a truncation.
    always_comb begin
        zero_above = 1'b1;
        blank_c    = '0;
        for (int k = DECIMAL_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above & (disp[4*k +: 4] == 4'd0);
            if (k != 0 && !ovf_c) blank_c[k] = zero_above;
        end
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            shreg    <= '0;
            bcd_reg  <= '0;
            cnt      <= '0;
            sign_lat <= 1'b0;
            bcd_q    <= '0;
            sign_q   <= 1'b0;
            blank_q  <= '0;
            ovf_q    <= 1'b0;
            dv_q     <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            if (accept) begin
                shreg    <= mag;
                bcd_reg  <= '0;
                cnt      <= '0;
                sign_lat <= neg;
            end else if (state == S_CONVERT) begin
                // {BCD, magnitude} << 1 with the magnitude MSB entering BCD bit 0
                bcd_reg <= {adj[NI*4-2:0], shreg[INPUT_WIDTH-1]};
                shreg   <= {shreg[INPUT_WIDTH-2:0], 1'b0};
                cnt     <= cnt + CW'(1);
            end else if (state == S_FINISH) begin
                bcd_q   <= disp;
                sign_q  <= sign_lat;
                blank_q <= blank_c;
                ovf_q   <= ovf_c;
                dv_q    <= 1'b1;
            end
        end
    end

    assign bus.bcd      = bcd_q;
    assign bus.sign     = sign_q;
    assign bus.blank    = blank_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = busy_c;
    assign bus.dv       = dv_q;
endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_binary_to_bcd_seq
//   Four converter instances cover the configurations of interest:
//     dut 0: W=8,  D=3, unsigned
//     dut 1: W=8,  D=3, signed
//     dut 2: W=16, D=5, unsigned
//     dut 3: W=16, D=3, unsigned (overflow possible)
//   A table of directed vectors with hand-computed results is followed by
//   hand-written handshake, back-to-back and reset-abort sequences.
// ---------------------------------------------------------------------------
module tb_binary_to_bcd_seq;
    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    binary_to_bcd_seq_if #(.INPUT_WIDTH(8),  .DECIMAL_DIGITS(3)) if0 ();
    binary_to_bcd_seq_if #(.INPUT_WIDTH(8),  .DECIMAL_DIGITS(3)) if1 ();
    binary_to_bcd_seq_if #(.INPUT_WIDTH(16), .DECIMAL_DIGITS(5)) if2 ();
    binary_to_bcd_seq_if #(.INPUT_WIDTH(16), .DECIMAL_DIGITS(3)) if3 ();
    logic [1:0] st0, st1, st2, st3;

    binary_to_bcd_seq #(.INPUT_WIDTH(8),  .DECIMAL_DIGITS(3), .SIGNED(0)) u0 (
        .i_Clock(clk), .i_Reset_n(rst_n), .bus(if0.slave), .dbg_state(st0));
    binary_to_bcd_seq #(.INPUT_WIDTH(8),  .DECIMAL_DIGITS(3), .SIGNED(1)) u1 (
        .i_Clock(clk), .i_Reset_n(rst_n), .bus(if1.slave), .dbg_state(st1));
    binary_to_bcd_seq #(.INPUT_WIDTH(16), .DECIMAL_DIGITS(5), .SIGNED(0)) u2 (
        .i_Clock(clk), .i_Reset_n(rst_n), .bus(if2.slave), .dbg_state(st2));
    binary_to_bcd_seq #(.INPUT_WIDTH(16), .DECIMAL_DIGITS(3), .SIGNED(0)) u3 (
        .i_Clock(clk), .i_Reset_n(rst_n), .bus(if3.slave), .dbg_state(st3));

    // ---------------- scoreboard counters ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver / monitor tasks ----------------
    logic [19:0] o_bcd;
    logic        o_sign;
    logic [4:0]  o_blank;
    logic        o_ovf;
    logic        o_busy;
    logic        o_dv;

    task automatic set_in(input int dut, input logic [15:0] v, input logic s);
        case (dut)
            0: begin if0.binary = v[7:0]; if0.start = s; end
            1: begin if1.binary = v[7:0]; if1.start = s; end
            2: begin if2.binary = v;      if2.start = s; end
            default: begin if3.binary = v; if3.start = s; end
        endcase
    endtask

    task automatic sample(input int dut);
        case (dut)
            0: begin o_bcd = 20'(if0.bcd); o_sign = if0.sign; o_blank = 5'(if0.blank);
                     o_ovf = if0.overflow; o_busy = if0.busy; o_dv = if0.dv; end
            1: begin o_bcd = 20'(if1.bcd); o_sign = if1.sign; o_blank = 5'(if1.blank);
                     o_ovf = if1.overflow; o_busy = if1.busy; o_dv = if1.dv; end
            2: begin o_bcd = if2.bcd; o_sign = if2.sign; o_blank = if2.blank;
                     o_ovf = if2.overflow; o_busy = if2.busy; o_dv = if2.dv; end
            default: begin o_bcd = 20'(if3.bcd); o_sign = if3.sign; o_blank = 5'(if3.blank);
                     o_ovf = if3.overflow; o_busy = if3.busy; o_dv = if3.dv; end
        endcase
    endtask

    // Pulse start for one accepting edge, then scramble binary to show it is
    // not re-sampled. Returns #1 after the edge where dv was seen; lat counts
    // edges after the accepting edge (bounded).
    task automatic run_conv(input int dut, input logic [15:0] v, output int lat);
        @(negedge clk);
        set_in(dut, v, 1'b1);
        @(posedge clk);
        #1;
        sample(dut);
        check("busy_after_accept", 64'(o_busy), 64'd1);
        set_in(dut, ~v, 1'b0);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
            sample(dut);
        end while (!o_dv && lat < 60);
        check("busy_at_dv", 64'(o_busy), 64'd0);
    endtask

    // Count dv pulses over a fixed window of edges.
    task automatic count_dv(input int dut, input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            sample(dut);
            if (o_dv) n++;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          dut;
        logic [15:0] val;
        logic [19:0] bcd;
        logic        sign;
        logic [4:0]  blank;
        logic        ovf;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int lat;
        int n;
        int w;

        vecs[0]  = '{0, 16'd255,   20'h00255, 1'b0, 5'b00000, 1'b0};
        vecs[1]  = '{0, 16'd7,     20'h00007, 1'b0, 5'b00110, 1'b0};
        vecs[2]  = '{0, 16'd40,    20'h00040, 1'b0, 5'b00100, 1'b0};
        vecs[3]  = '{1, 16'h0080,  20'h00128, 1'b1, 5'b00000, 1'b0};
        vecs[4]  = '{1, 16'h00FF,  20'h00001, 1'b1, 5'b00110, 1'b0};
        vecs[5]  = '{1, 16'h007F,  20'h00127, 1'b0, 5'b00000, 1'b0};
        vecs[6]  = '{1, 16'h0000,  20'h00000, 1'b0, 5'b00110, 1'b0};
        vecs[7]  = '{2, 16'd0,     20'h00000, 1'b0, 5'b11110, 1'b0};
        vecs[8]  = '{2, 16'd65535, 20'h65535, 1'b0, 5'b00000, 1'b0};
        vecs[9]  = '{2, 16'd120,   20'h00120, 1'b0, 5'b11000, 1'b0};
        vecs[10] = '{2, 16'd9999,  20'h09999, 1'b0, 5'b10000, 1'b0};
        vecs[11] = '{3, 16'd1000,  20'h00000, 1'b0, 5'b00000, 1'b1};
        vecs[12] = '{3, 16'd999,   20'h00999, 1'b0, 5'b00000, 1'b0};
        vecs[13] = '{3, 16'd65535, 20'h00535, 1'b0, 5'b00000, 1'b1};
        vecs[14] = '{3, 16'd5,     20'h00005, 1'b0, 5'b00110, 1'b0};

        for (int d = 0; d < 4; d++) set_in(d, 16'd0, 1'b0);

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d += 2) begin
            sample(d);
            check("reset_bcd",   64'(o_bcd),   64'd0);
            check("reset_sign",  64'(o_sign),  64'd0);
            check("reset_blank", 64'(o_blank), 64'd0);
            check("reset_ovf",   64'(o_ovf),   64'd0);
            check("reset_busy",  64'(o_busy),  64'd0);
            check("reset_dv",    64'(o_dv),    64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // ---- table-driven vectors ----
        foreach (vecs[i]) begin
            w = (vecs[i].dut < 2) ? 8 : 16;
            run_conv(vecs[i].dut, vecs[i].val, lat);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(w + 1));
            check($sformatf("v%0d_bcd", i),   64'(o_bcd),   64'(vecs[i].bcd));
            check($sformatf("v%0d_sign", i),  64'(o_sign),  64'(vecs[i].sign));
            check($sformatf("v%0d_blank", i), 64'(o_blank), 64'(vecs[i].blank));
            check($sformatf("v%0d_ovf", i),   64'(o_ovf),   64'(vecs[i].ovf));
        end

        // ---- start during conversion is ignored ----
        @(negedge clk);
        set_in(0, 16'd200, 1'b1);
        @(posedge clk);                // E0
        #1 set_in(0, 16'd200, 1'b0);
        lat = 0;
        repeat (2) begin @(posedge clk); lat++; end
        #1 set_in(0, 16'd99, 1'b1);    // seen at E3, while busy
        @(posedge clk);
        lat++;
        #1 set_in(0, 16'd99, 1'b0);
        sample(0);
        while (!o_dv && lat < 60) begin
            @(posedge clk);
            lat++;
            #1 sample(0);
        end
        check("ign_latency", 64'(lat), 64'd9);
        check("ign_bcd", 64'(o_bcd), 64'h200);
        count_dv(0, 20, n);
        check("ign_no_extra_dv", 64'(n), 64'd0);

        // ---- back-to-back: start in the dv cycle ----
        run_conv(0, 16'd123, lat);
        check("b2b_first_bcd", 64'(o_bcd), 64'h123);
        set_in(0, 16'd45, 1'b1);
        @(posedge clk);                // accepted in the dv cycle
        #1 set_in(0, 16'd45, 1'b0);
        sample(0);
        check("b2b_dv_falls", 64'(o_dv), 64'd0);
        check("b2b_busy", 64'(o_busy), 64'd1);
        check("b2b_result_held", 64'(o_bcd), 64'h123);
        lat = 1;
        while (!o_dv && lat < 60) begin
            @(posedge clk);
            lat++;
            #1 sample(0);
        end
        check("b2b_spacing", 64'(lat), 64'd10);
        check("b2b_second_bcd", 64'(o_bcd), 64'h045);
        check("b2b_second_blank", 64'(o_blank), 64'b100);

        // ---- reset mid-conversion ----
        @(negedge clk);
        set_in(0, 16'd250, 1'b1);
        @(posedge clk);
        #1 set_in(0, 16'd250, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 sample(0);
        check("rst_mid_bcd",   64'(o_bcd),   64'd0);
        check("rst_mid_blank", 64'(o_blank), 64'd0);
        check("rst_mid_busy",  64'(o_busy),  64'd0);
        check("rst_mid_dv",    64'(o_dv),    64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        count_dv(0, 20, n);
        check("rst_no_dv", 64'(n), 64'd0);
        run_conv(0, 16'd42, lat);
        check("rst_after_latency", 64'(lat), 64'd9);
        check("rst_after_bcd", 64'(o_bcd), 64'h042);
        check("rst_after_blank", 64'(o_blank), 64'b100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
